// File: rtl/fc1_weight_stream_pkg.sv
// Shared constants for the FC1 weight streamer: lane geometry, layer shape and stream FSM encodings.
package fc1_weight_stream_pkg;

    localparam int unsigned NUM_PE     = 4;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned WORD_W     = NUM_PE * LANE_W;
    localparam int unsigned IN1_N      = 132;
    localparam int unsigned OUT1_M     = 10;
    localparam int unsigned GROUPS     = IN1_N / NUM_PE;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned ROW_W      = 4;
    localparam int unsigned GRP_W      = $clog2(GROUPS);

    // Lane p of a group word occupies bits [LANE_W*p +: LANE_W], lane 0 in the low byte.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/fc1_weight_stream_fifo.sv
// Word FIFO with combinational head read, registered level/full and synchronous flush.
module fc1_weight_stream_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push_c;

    // Writes into a full FIFO are dropped; the caller flags the overflow.
    assign push_c    = wr_en && !full_q && !flush;
    assign rd_data_c = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign level     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + LW'(push_c) - LW'(rd_en);
            full_d  = (count_d == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/fc1_weight_stream.sv
// Buffers host FC1 weight words and hands them to the FC engine one group at a time,
// tracking group/row position and sticky overflow/underflow/done flags.
module fc1_weight_stream
    import fc1_weight_stream_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WORD_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     fc1_next,
    output logic [WORD_W-1:0]        fc1_w,
    output logic                     fc1_valid,
    output logic                     last_group,
    output logic [ROW_W-1:0]         row_idx,
    output logic                     all_done,
    output logic                     overflow,
    output logic                     underflow
);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] fc1_w_q, fc1_w_d;
    logic              valid_q, valid_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              last_group_q, last_group_d;
    logic              all_done_q, all_done_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              pop_c;
    logic              last_of_all_c;
    logic [WORD_W-1:0] rd_data_c;

    fc1_weight_stream_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (pop_c),
        .rd_data_c (rd_data_c),
        .full      (full),
        .level     (level)
    );

    assign last_of_all_c = (row_q == ROW_W'(OUT1_M - 1)) && (grp_q == GRP_W'(GROUPS - 1));

    // Stream FSM: load the output register from the FIFO head and advance on fc1_next.
    always_comb begin
        state_d      = state_q;
        fc1_w_d      = fc1_w_q;
        valid_d      = valid_q;
        grp_d        = grp_q;
        row_d        = row_q;
        all_done_d   = all_done_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        last_group_d = last_group_q;
        pop_c        = 1'b0;
        if (flush) begin
            state_d      = S_EMPTY;
            fc1_w_d      = '0;
            valid_d      = 1'b0;
            grp_d        = '0;
            row_d        = '0;
            all_done_d   = 1'b0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
            last_group_d = 1'b0;
        end else begin
            if (wr_en && full) overflow_d = 1'b1;
            case (state_q)
                S_EMPTY: begin
                    if (fc1_next) underflow_d = 1'b1;
                    if (level != '0) begin
                        pop_c   = 1'b1;
                        fc1_w_d = rd_data_c;
                        valid_d = 1'b1;
                        state_d = S_VALID;
                    end
                end
                S_VALID: begin
                    if (fc1_next) begin
                        if (grp_q == GRP_W'(GROUPS - 1)) begin
                            grp_d = '0;
                            if (!last_of_all_c) row_d = row_q + ROW_W'(1);
                        end else begin
                            grp_d = grp_q + GRP_W'(1);
                        end
                        if (last_of_all_c) begin
                            valid_d    = 1'b0;
                            all_done_d = 1'b1;
                            state_d    = S_DONE;
                        end else if (level != '0) begin
                            pop_c   = 1'b1;
                            fc1_w_d = rd_data_c;
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_EMPTY;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_EMPTY;
                    valid_d = 1'b0;
                end
            endcase
            last_group_d = valid_d && (grp_d == GRP_W'(GROUPS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_EMPTY;
            fc1_w_q      <= '0;
            valid_q      <= 1'b0;
            grp_q        <= '0;
            row_q        <= '0;
            last_group_q <= 1'b0;
            all_done_q   <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fc1_w_q      <= fc1_w_d;
            valid_q      <= valid_d;
            grp_q        <= grp_d;
            row_q        <= row_d;
            last_group_q <= last_group_d;
            all_done_q   <= all_done_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign fc1_w      = fc1_w_q;
    assign fc1_valid  = valid_q;
    assign last_group = last_group_q;
    assign row_idx    = row_q;
    assign all_done   = all_done_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
